spi_frame_packer: RTL and testbench
===================================

SPI_FRAME_PACKER -- requirements
Module: spi_frame_packer

Interface
REQ-001 The block SHALL have parameter WORD_BYTES, default 4, meaning bytes per FIFO word (1..4).
REQ-002 The block SHALL have parameter WORDS_PER_FRAME, default 8, meaning FIFO words per frame (1..255).
REQ-003 The block SHALL have parameter CNT_W, default 9, meaning width of fifo_content.
REQ-004 The block SHALL have parameter CMD_BYTE, default 8'h02, meaning the first header byte, the ESP write command.
REQ-005 The block SHALL have parameter ESP_ADDR, default 8'h00, meaning the second header byte, the ESP buffer start address.
REQ-006 The block SHALL have port clock, input, 1, meaning the single clock (all logic on its rising edge).
REQ-007 The block SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-008 The block SHALL have port data, input, 8*WORD_BYTES, meaning the FIFO head word (show-ahead).
REQ-009 The block SHALL have port fifo_content, input, CNT_W, meaning the FIFO fill level in words.
REQ-010 The block SHALL have port send, input, 1, meaning the frame start request (level).
REQ-011 The block SHALL have port di_req, input, 1, meaning the SPI slave requests the next byte.
REQ-012 The block SHALL have port write_ack, input, 1, meaning the SPI slave latched the byte (rising edge counts).
REQ-013 The block SHALL have port byte_out, output, 8, meaning the byte offered to the SPI slave.
REQ-014 The block SHALL have port wren, output, 1, meaning byte_out is valid.
REQ-015 The block SHALL have port fifo_read, output, 1, meaning a one-cycle FIFO pop pulse.
REQ-016 The block SHALL have ports busy, output, 1, meaning a frame is in progress; frame_done, output, 1, meaning a one-cycle pulse after the final byte ack; send_rejected, output, 1, meaning a one-cycle pulse when send is refused.

Function
REQ-017 The FSM SHALL have states IDLE, CMD, ADDR, DATA, CSUM and DONE, and a frame SHALL be CMD_BYTE, ESP_ADDR, then WORDS_PER_FRAME*WORD_BYTES data bytes (CSUM only per REQ-032).
REQ-018 In IDLE, if send=1 and fifo_content>=WORDS_PER_FRAME, the next cycle SHALL have byte_out=CMD_BYTE, wren=1, busy=1 and state CMD.
REQ-019 In IDLE, if send=1 and fifo_content<WORDS_PER_FRAME, send_rejected SHALL pulse for one cycle, the state SHALL stay IDLE, and a held send SHALL pulse it again every cycle.
REQ-020 send SHALL be ignored while busy=1.
REQ-021 An ack edge SHALL be write_ack=1 with the registered prior write_ack=0; an ack edge SHALL clear wren next cycle and set internal flag need_next.
REQ-022 An ack edge while wren=0 SHALL be ignored: no counter advance, need_next unchanged.
REQ-023 When need_next=1 and di_req=1, the next byte of the frame SHALL be loaded into byte_out with wren=1 and need_next cleared; while di_req=0 the load SHALL wait indefinitely.
REQ-024 A load SHALL never occur in the same cycle as the ack edge that set need_next, giving a minimum gap of 2 cycles from ack edge to new wren.
REQ-025 Data bytes SHALL be sent LSB first: byte index k within a word SHALL be data[8k+7:8k].
REQ-026 fifo_read SHALL pulse for exactly one cycle, coincident with loading byte index WORD_BYTES-1 of each word, giving WORDS_PER_FRAME pulses per frame.
REQ-027 The byte counter SHALL be $clog2(WORDS_PER_FRAME*WORD_BYTES+1) bits wide and SHALL never wrap within a frame.
REQ-028 After the ack edge of the last byte, the state SHALL be DONE for one cycle with frame_done=1 and wren=0, then IDLE with busy=0.
REQ-029 send asserted during DONE SHALL be ignored; it SHALL be evaluated on the first IDLE cycle.

Reset
REQ-030 reset_n=0 SHALL asynchronously force IDLE, byte_out=0, wren=0, fifo_read=0, busy=0, frame_done=0, send_rejected=0, need_next=0, the prior write_ack register=0, all counters=0 and the checksum accumulator=0.
REQ-031 Reset mid-frame SHALL abort the frame with no further fifo_read pulse; FIFO words already popped SHALL be lost.

Configuration
REQ-032 With SPI_FRAME_CHECKSUM_EN defined, a final byte SHALL follow the data bytes in state CSUM, equal to the XOR of all data bytes of the frame (header bytes excluded), handled with the same handshake as data bytes and acked before DONE; without it, CSUM SHALL be unreachable, the frame SHALL end after the last data byte, and no accumulator logic SHALL exist.

Verification
REQ-033 Defaults, fifo_content=8, send pulse, slave acking every byte -> bytes 02,00 then 32 data bytes LSB first; 8 fifo_read pulses; one frame_done.
REQ-034 fifo_content=7, send=1 held for 3 cycles -> 3 send_rejected pulses; wren stays 0; busy stays 0.
REQ-035 di_req held 0 for 20 cycles after an ack -> wren stays 0; byte_out unchanged; no fifo_read; on di_req=1 the next byte loads the next cycle.
REQ-036 Spurious write_ack edge while wren=0, then send during busy -> no byte skipped; no second frame starts.
REQ-037 reset_n pulsed low after 10 data bytes -> all outputs 0 asynchronously; a new send with fifo_content=8 restarts with CMD_BYTE.
REQ-038 SPI_FRAME_CHECKSUM_EN, WORD_BYTES=2, WORDS_PER_FRAME=1, data=16'hA55A -> bytes 02,00,5A,A5,FF.

Source files
------------

// File: rtl/spi_frame_packer.sv
// spi_frame_packer: pulls WORDS_PER_FRAME words from a show-ahead FIFO and
// presents them to an SPI slave one byte at a time. Each frame is CMD_BYTE,
// ESP_ADDR and then the data bytes, least significant byte of each word first.
// Optional feature macro: SPI_FRAME_CHECKSUM_EN appends one byte holding the
// XOR of all data bytes of the frame.
//
// Byte handshake: wren=1 means byte_out is valid and held stable. The slave
// accepts it with a rising edge on write_ack. wren then drops, and the next
// byte is offered only after the slave asks for it with di_req=1. An ack edge
// seen while wren=0 is ignored.
module spi_frame_packer #(
  parameter int          WORD_BYTES      = 4,
  parameter int          WORDS_PER_FRAME = 8,
  parameter int          CNT_W           = 9,
  parameter logic [7:0]  CMD_BYTE        = 8'h02,
  parameter logic [7:0]  ESP_ADDR        = 8'h00
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [8*WORD_BYTES-1:0] data,
  input  logic [CNT_W-1:0]        fifo_content,
  input  logic                    send,
  input  logic                    di_req,
  input  logic                    write_ack,
  output logic [7:0]              byte_out,
  output logic                    wren,
  output logic                    fifo_read,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    send_rejected,
  output logic [2:0]              dbg_state
);

  localparam int TOTAL = WORDS_PER_FRAME * WORD_BYTES;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] TOTAL_CW = CW'(TOTAL);
  localparam logic [1:0]    IDX_LAST = 2'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t          state_q;
  logic            need_next_q;
  logic            ack_prev_q;
  logic [CW-1:0]   byte_cnt_q;   // data bytes loaded so far in this frame
  logic [1:0]      idx_q;        // byte index within the current FIFO word
`ifdef SPI_FRAME_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic            ack_hit;
  logic            load_ok;
  logic            frame_ok;
  logic            last_data;
  logic [7:0]      cur_byte;

  assign dbg_state = state_q;

  // Handshake qualifiers and the byte of the head word selected by idx_q.
  always_comb begin
    ack_hit   = write_ack & ~ack_prev_q & wren;
    load_ok   = need_next_q & di_req;
    frame_ok  = (fifo_content >= CNT_W'(WORDS_PER_FRAME));
    last_data = (byte_cnt_q == TOTAL_CW);
    cur_byte  = 8'h00;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (idx_q == 2'(k)) cur_byte = data[8*k +: 8];
    end
  end

  // Frame sequencer with registered handshake outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      byte_out      <= 8'h00;
      wren          <= 1'b0;
      fifo_read     <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      send_rejected <= 1'b0;
      need_next_q   <= 1'b0;
      ack_prev_q    <= 1'b0;
      byte_cnt_q    <= '0;
      idx_q         <= 2'd0;
`ifdef SPI_FRAME_CHECKSUM_EN
      csum_q        <= 8'h00;
`endif
    end else begin
      ack_prev_q    <= write_ack;
      fifo_read     <= 1'b0;
      frame_done    <= 1'b0;
      send_rejected <= 1'b0;
      case (state_q)
        IDLE: begin
          if (send) begin
            if (frame_ok) begin
              state_q     <= CMD;
              byte_out    <= CMD_BYTE;
              wren        <= 1'b1;
              busy        <= 1'b1;
              need_next_q <= 1'b0;
              byte_cnt_q  <= '0;
              idx_q       <= 2'd0;
`ifdef SPI_FRAME_CHECKSUM_EN
              csum_q      <= 8'h00;
`endif
            end else begin
              send_rejected <= 1'b1;
            end
          end
        end
        CMD: begin
          if (ack_hit) begin
            wren        <= 1'b0;
            need_next_q <= 1'b1;
          end else if (load_ok) begin
            byte_out    <= ESP_ADDR;
            wren        <= 1'b1;
            need_next_q <= 1'b0;
            state_q     <= ADDR;
          end
        end
        ADDR, DATA: begin
          if (ack_hit) begin
            wren <= 1'b0;
            if (state_q == DATA && last_data) begin
`ifdef SPI_FRAME_CHECKSUM_EN
              need_next_q <= 1'b1;
`else
              state_q     <= DONE;
              frame_done  <= 1'b1;
`endif
            end else begin
              need_next_q <= 1'b1;
            end
          end else if (load_ok) begin
            need_next_q <= 1'b0;
            wren        <= 1'b1;
`ifdef SPI_FRAME_CHECKSUM_EN
            if (state_q == DATA && last_data) begin
              byte_out <= csum_q;
              state_q  <= CSUM;
            end else
`endif
            begin
              byte_out   <= cur_byte;
              state_q    <= DATA;
              byte_cnt_q <= byte_cnt_q + CW'(1);
`ifdef SPI_FRAME_CHECKSUM_EN
              csum_q     <= csum_q ^ cur_byte;
`endif
              // Pop the word together with loading its last byte.
              if (idx_q == IDX_LAST) begin
                idx_q     <= 2'd0;
                fifo_read <= 1'b1;
              end else begin
                idx_q <= idx_q + 2'd1;
              end
            end
          end
        end
`ifdef SPI_FRAME_CHECKSUM_EN
        CSUM: begin
          if (ack_hit) begin
            wren       <= 1'b0;
            state_q    <= DONE;
            frame_done <= 1'b1;
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_packer.sv
// Bench for spi_frame_packer: default instance (4-byte words, 8 words) fed by
// a show-ahead FIFO model, plus a small instance (2-byte word, 1 word) with a
// fixed head word. A shared slave model serves either instance.
module tb_spi_frame_packer;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- instance 1 (defaults) ----------------
  logic [31:0] data1;
  logic [8:0]  fifo_content1 = 9'd0;
  logic        send1 = 1'b0;
  logic        di_req = 1'b1;
  logic        ack_drv = 1'b0;
  logic        sel = 1'b0;
  logic        write_ack1, write_ack2;
  logic [7:0]  byte_out1;
  logic        wren1, fifo_read1, busy1, frame_done1, send_rejected1;
  logic [2:0]  dbg_state1;

  assign write_ack1 = ack_drv & ~sel;
  assign write_ack2 = ack_drv & sel;

  spi_frame_packer u_dut (
    .clock(clock), .reset_n(reset_n), .data(data1), .fifo_content(fifo_content1),
    .send(send1), .di_req(di_req), .write_ack(write_ack1), .byte_out(byte_out1),
    .wren(wren1), .fifo_read(fifo_read1), .busy(busy1), .frame_done(frame_done1),
    .send_rejected(send_rejected1), .dbg_state(dbg_state1)
  );

  // ---------------- instance 2 (2-byte word, 1 word per frame) ----------------
  logic [15:0] data2 = 16'hA55A;
  logic [8:0]  fifo_content2 = 9'd1;
  logic        send2 = 1'b0;
  logic [7:0]  byte_out2;
  logic        wren2, fifo_read2, busy2, frame_done2, send_rejected2;
  logic [2:0]  dbg_state2;

  spi_frame_packer #(.WORD_BYTES(2), .WORDS_PER_FRAME(1)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .data(data2), .fifo_content(fifo_content2),
    .send(send2), .di_req(di_req), .write_ack(write_ack2), .byte_out(byte_out2),
    .wren(wren2), .fifo_read(fifo_read2), .busy(busy2), .frame_done(frame_done2),
    .send_rejected(send_rejected2), .dbg_state(dbg_state2)
  );

  logic [7:0] o_byte;
  logic       o_wren, o_busy;
  assign o_byte = sel ? byte_out2 : byte_out1;
  assign o_wren = sel ? wren2 : wren1;
  assign o_busy = sel ? busy2 : busy1;

  // ---------------- show-ahead FIFO model for instance 1 ----------------
  logic [31:0] words [64];
  logic [5:0]  rd_ptr = 6'd0;
  assign data1 = words[rd_ptr];
  always @(posedge clock) if (fifo_read1) rd_ptr <= rd_ptr + 6'd1;

  function automatic logic [7:0] byte_val(input int j);
    return 8'(8'h40 + j);
  endfunction

  // ---------------- event monitor ----------------
  int pop_cnt = 0, done_cnt = 0, rej_cnt = 0, wren_cnt = 0, busy_cnt = 0;
  int pop2_cnt = 0, done2_cnt = 0;
  always @(negedge clock) begin
    if (fifo_read1)     pop_cnt++;
    if (frame_done1)    done_cnt++;
    if (send_rejected1) rej_cnt++;
    if (wren1)          wren_cnt++;
    if (busy1)          busy_cnt++;
    if (fifo_read2)     pop2_cnt++;
    if (frame_done2)    done2_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int exp_ptr = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input int p);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    for (int m = 0; m < 32; m++) begin
      b = byte_val(4 * p + m);
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef SPI_FRAME_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: pulse send for one cycle and check the CMD byte.
  task automatic start_frame(input bit which);
    if (which) send2 = 1'b1; else send1 = 1'b1;
    @(negedge clock);
    send1 = 1'b0;
    send2 = 1'b0;
    check_val("start_wren", o_wren, 1);
    check_val("start_byte", o_byte, 8'h02);
    check_val("start_busy", o_busy, 1);
  endtask

  // Slave model: accept n bytes, optionally stalling di_req after byte
  // stall_at (with a spurious ack and a send during busy if spur), and
  // optionally returning right after acking byte abort_at.
  task automatic serve(input int n, input int stall_at, input int stall_len,
                       input bit spur, input int abort_at);
    int t;
    int bad_wren;
    int bad_byte;
    int pop0;
    logic [7:0] held;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!o_wren && t < 40) begin
        @(negedge clock);
        t++;
      end
      if (!o_wren) begin
        check_val("wren_timeout", 0, 1);
        return;
      end
      if (exp_q.size() == 0) begin
        check_val("extra_byte", o_byte, 32'hFFFF_FFFF);
        e = 8'h00;
      end else begin
        e = exp_q.pop_front();
        check_val("byte", o_byte, e);
      end
      ack_drv = 1'b1;
      @(negedge clock);
      ack_drv = 1'b0;
      if (i == abort_at) return;
      if (i == stall_at) begin
        di_req   = 1'b0;
        held     = o_byte;
        bad_wren = 0;
        bad_byte = 0;
        pop0     = pop_cnt;
        if (spur) send1 = 1'b1;
        for (int j = 0; j < stall_len; j++) begin
          @(negedge clock);
          if (o_wren) bad_wren++;
          if (o_byte !== held) bad_byte++;
          ack_drv = spur && (j == 5);
        end
        ack_drv = 1'b0;
        check_val("stall_wren", bad_wren, 0);
        check_val("stall_byte", bad_byte, 0);
        check_val("stall_pop", pop_cnt - pop0, 0);
        di_req = 1'b1;
        send1  = 1'b0;
        @(negedge clock);
        check_val("resume_wren", o_wren, 1);
      end
    end
  endtask

  // Called at the negedge where serve returned after the last ack.
  task automatic check_frame_end();
    check_val("done_pulse", sel ? frame_done2 : frame_done1, 1);
    check_val("done_wren", o_wren, 0);
    @(negedge clock);
    check_val("idle_busy", o_busy, 0);
    check_val("idle_done", sel ? frame_done2 : frame_done1, 0);
    check_val("idle_state", sel ? dbg_state2 : dbg_state1, 0);
    @(negedge clock);
  endtask

  localparam int NB1 =
`ifdef SPI_FRAME_CHECKSUM_EN
    35;
`else
    34;
`endif

  // ---------------- main sequence ----------------
  initial begin
    int p0, d0, r0, w0, b0;
    for (int i = 0; i < 64; i++)
      words[i] = {byte_val(4*i+3), byte_val(4*i+2), byte_val(4*i+1), byte_val(4*i)};

    // Reset state
    repeat (3) @(negedge clock);
    check_val("rst_wren", wren1, 0);
    check_val("rst_busy", busy1, 0);
    check_val("rst_byte", byte_out1, 0);
    check_val("rst_pop", fifo_read1, 0);
    check_val("rst_state", dbg_state1, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Full default frame
    fifo_content1 = 9'd8;
    p0 = pop_cnt; d0 = done_cnt;
    push_frame(exp_ptr);
    start_frame(1'b0);
    serve(NB1, -1, 0, 1'b0, -1);
    check_frame_end();
    exp_ptr += 8;
    check_val("f1_pops", pop_cnt - p0, 8);
    check_val("f1_done", done_cnt - d0, 1);
    check_val("f1_ptr", rd_ptr, exp_ptr);

    // Rejected send with too few words
    fifo_content1 = 9'd7;
    r0 = rej_cnt; w0 = wren_cnt; b0 = busy_cnt;
    send1 = 1'b1;
    repeat (3) @(negedge clock);
    send1 = 1'b0;
    repeat (2) @(negedge clock);
    check_val("rej_pulses", rej_cnt - r0, 3);
    check_val("rej_wren", wren_cnt - w0, 0);
    check_val("rej_busy", busy_cnt - b0, 0);

    // di_req stalled for 20 cycles before a word-final byte
    fifo_content1 = 9'd8;
    p0 = pop_cnt;
    push_frame(exp_ptr);
    start_frame(1'b0);
    serve(NB1, 4, 20, 1'b0, -1);
    check_frame_end();
    exp_ptr += 8;
    check_val("stall_pops", pop_cnt - p0, 8);

    // Spurious ack while wren=0 and send during busy
    p0 = pop_cnt; d0 = done_cnt;
    push_frame(exp_ptr);
    start_frame(1'b0);
    serve(NB1, 6, 10, 1'b1, -1);
    check_frame_end();
    exp_ptr += 8;
    repeat (3) @(negedge clock);
    check_val("spur_pops", pop_cnt - p0, 8);
    check_val("spur_done", done_cnt - d0, 1);
    check_val("spur_idle", busy1, 0);
    check_val("spur_ptr", rd_ptr, exp_ptr);

    // Reset after 10 data bytes
    p0 = pop_cnt;
    push_frame(exp_ptr);
    start_frame(1'b0);
    serve(NB1, -1, 0, 1'b0, 11);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst_wren", wren1, 0);
    check_val("arst_busy", busy1, 0);
    check_val("arst_byte", byte_out1, 0);
    check_val("arst_state", dbg_state1, 0);
    check_val("arst_flags", {fifo_read1, frame_done1, send_rejected1}, 0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    exp_ptr += 2;
    check_val("arst_pops", pop_cnt - p0, 2);
    check_val("arst_ptr", rd_ptr, exp_ptr);
    push_frame(exp_ptr);
    start_frame(1'b0);
    serve(NB1, -1, 0, 1'b0, -1);
    check_frame_end();
    exp_ptr += 8;
    check_val("restart_ptr", rd_ptr, exp_ptr);

    // Small instance: one 2-byte word 16'hA55A
    sel = 1'b1;
    p0 = pop2_cnt; d0 = done2_cnt;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
`ifdef SPI_FRAME_CHECKSUM_EN
    exp_q.push_back(8'hFF);
    start_frame(1'b1);
    serve(5, -1, 0, 1'b0, -1);
`else
    start_frame(1'b1);
    serve(4, -1, 0, 1'b0, -1);
`endif
    check_frame_end();
    check_val("small_pops", pop2_cnt - p0, 1);
    check_val("small_done", done2_cnt - d0, 1);
    check_val("small_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
